// File: rtl/layer1_weight_sequencer.sv
// layer1_weight_sequencer: owns the layer-1 weight store port; packs word streams into rows (LOAD)
// and streams stored rows to the MAC array over a valid/ready link (SCAN).
module layer1_weight_sequencer #(
    parameter int NODE_COUNT    = 784,
    parameter int ADDR_WIDTH    = 10,
    parameter int WORD_WIDTH    = 8,
    parameter int WORDS_PER_ROW = 16,
    localparam int ROW_WIDTH    = WORDS_PER_ROW * WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  loadStart,
    input  logic                  scanStart,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] loadWord,
    input  logic                  loadValid,
    output logic                  loadReady,
    output logic [ROW_WIDTH-1:0]  rowOut,
    output logic [ADDR_WIDTH-1:0] rowIndex,
    output logic                  rowValid,
    input  logic                  rowReady,
    output logic                  busy,
    output logic                  loadDone,
    output logic                  scanDone,
    output logic                  storeWriteEnable,
    output logic [ADDR_WIDTH-1:0] storeNodeSelect,
    output logic [ROW_WIDTH-1:0]  storeWriteIn,
    input  logic [ROW_WIDTH-1:0]  storeReadOut
);
    localparam int WCW = WORDS_PER_ROW > 1 ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NODE_COUNT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_FILL, LOAD_WRITE, SCAN_ADDR, SCAN_OUT} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] row, row_d;
    logic [WCW-1:0]        word, word_d;
    logic [ROW_WIDTH-1:0]  assembly, assembly_d;
    logic                  accept;
    logic                  load_ready_d, row_valid_d, busy_d, load_done_d, scan_done_d, we_d;
    logic [ADDR_WIDTH-1:0] node_sel_d, row_index_d;
    logic [ROW_WIDTH-1:0]  write_in_d, row_out_d;

    assign accept = loadValid && loadReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            row              <= '0;
            word             <= '0;
            assembly         <= '0;
            loadReady        <= 1'b0;
            rowValid         <= 1'b0;
            busy             <= 1'b0;
            loadDone         <= 1'b0;
            scanDone         <= 1'b0;
            storeWriteEnable <= 1'b0;
            storeNodeSelect  <= '0;
            storeWriteIn     <= '0;
            rowOut           <= '0;
            rowIndex         <= '0;
        end else begin
            state            <= state_d;
            row              <= row_d;
            word             <= word_d;
            assembly         <= assembly_d;
            loadReady        <= load_ready_d;
            rowValid         <= row_valid_d;
            busy             <= busy_d;
            loadDone         <= load_done_d;
            scanDone         <= scan_done_d;
            storeWriteEnable <= we_d;
            storeNodeSelect  <= node_sel_d;
            storeWriteIn     <= write_in_d;
            rowOut           <= row_out_d;
            rowIndex         <= row_index_d;
        end
    end

    always_comb begin
        state_d    = state;
        row_d      = row;
        word_d     = word;
        assembly_d = assembly;
        if (accept) assembly_d[int'(word)*WORD_WIDTH +: WORD_WIDTH] = loadWord;
        case (state)
            IDLE:
                if (loadStart) begin
                    state_d = LOAD_FILL;
                    row_d   = '0;
                    word_d  = '0;
                end else if (scanStart) begin
                    state_d = SCAN_ADDR;
                    row_d   = '0;
                end
            LOAD_FILL:
                if (accept) begin
                    word_d = word + 1'b1;
                    if (word == LAST_WORD) state_d = LOAD_WRITE;
                end
            LOAD_WRITE:
                if (row == LAST_ROW) state_d = IDLE;
                else begin
                    state_d = LOAD_FILL;
                    row_d   = row + 1'b1;
                    word_d  = '0;
                end
            SCAN_ADDR: state_d = SCAN_OUT;
            SCAN_OUT:
                if (rowReady) begin
                    if (row == LAST_ROW) state_d = IDLE;
                    else begin
                        state_d = SCAN_ADDR;
                        row_d   = row + 1'b1;
                    end
                end
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) state_d = IDLE;
    end

    // Outputs are decoded from the next state so every port is a plain register.
    always_comb begin
        load_ready_d = state_d == LOAD_FILL;
        row_valid_d  = state_d == SCAN_OUT;
        busy_d       = state_d != IDLE;
        we_d         = state_d == LOAD_WRITE;
        load_done_d  = state == LOAD_WRITE && state_d == IDLE && !abort;
        scan_done_d  = state == SCAN_OUT && state_d == IDLE && !abort;
        node_sel_d   = (state_d == LOAD_WRITE || state_d == SCAN_ADDR) ? row_d : storeNodeSelect;
        write_in_d   = state_d == LOAD_WRITE ? assembly_d : storeWriteIn;
        row_out_d    = (state == SCAN_ADDR && state_d == SCAN_OUT) ? storeReadOut : rowOut;
        row_index_d  = (state == SCAN_ADDR && state_d == SCAN_OUT) ? row : rowIndex;
    end
endmodule

// File: tb/tb_layer1_weight_sequencer.sv
// tb_layer1_weight_sequencer: scoreboard bench for a 4-row x 4-word sequencer with a behavioural store.
module tb_layer1_weight_sequencer;
    localparam int NC = 4, AW = 10, WW = 8, WPR = 4, RW = WPR * WW;

    logic clk = 0, rst_n = 0, loadStart = 0, scanStart = 0, abort = 0, loadValid = 0, rowReady = 1;
    logic [WW-1:0] loadWord = '0;
    logic loadReady, rowValid, busy, loadDone, scanDone, storeWriteEnable;
    logic [RW-1:0] rowOut, storeWriteIn, storeReadOut;
    logic [AW-1:0] rowIndex, storeNodeSelect;

    logic [RW-1:0] mem [NC];
    logic [RW-1:0] model [NC];
    int exp_wa[$], exp_ra[$];
    logic [RW-1:0] exp_wd[$], exp_rd[$];
    int checks = 0, errors = 0, load_dones = 0, scan_dones = 0;
    int cyc, ld0, sd0, k;
    bit rv_seen;

    layer1_weight_sequencer #(.NODE_COUNT(NC), .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_ROW(WPR)) dut (
        .clk(clk), .rst_n(rst_n), .loadStart(loadStart), .scanStart(scanStart), .abort(abort),
        .loadWord(loadWord), .loadValid(loadValid), .loadReady(loadReady),
        .rowOut(rowOut), .rowIndex(rowIndex), .rowValid(rowValid), .rowReady(rowReady),
        .busy(busy), .loadDone(loadDone), .scanDone(scanDone),
        .storeWriteEnable(storeWriteEnable), .storeNodeSelect(storeNodeSelect),
        .storeWriteIn(storeWriteIn), .storeReadOut(storeReadOut)
    );

    always #5 clk = ~clk;

    assign storeReadOut = storeNodeSelect < NC ? mem[storeNodeSelect[1:0]] : '0;
    always @(posedge clk) if (storeWriteEnable && storeNodeSelect < NC) mem[storeNodeSelect[1:0]] <= storeWriteIn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes the store or hands over a row.
    always @(negedge clk) begin
        if (rst_n && storeWriteEnable) begin
            if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                chk("write_addr", storeNodeSelect, exp_wa.pop_front());
                chk("write_data", storeWriteIn, exp_wd.pop_front());
            end
        end
        if (rst_n && rowValid && rowReady) begin
            if (exp_ra.size() == 0) chk("unexpected_row", 1, 0);
            else begin
                chk("row_index", rowIndex, exp_ra.pop_front());
                chk("row_data", rowOut, exp_rd.pop_front());
            end
        end
        if (loadDone) load_dones++;
        if (scanDone) scan_dones++;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {loadReady, rowValid, busy, loadDone, scanDone, storeWriteEnable}, 0);
        chk({tag, "_rowout"}, rowOut, 0);
        chk({tag, "_rowidx"}, rowIndex, 0);
        chk({tag, "_nodesel"}, storeNodeSelect, 0);
        chk({tag, "_wrin"}, storeWriteIn, 0);
    endtask

    task automatic do_load(input int base, input bit with_scan, output int n);
        int w;
        logic [RW-1:0] d;
        for (int r = 0; r < NC; r++) begin
            for (int j = 0; j < WPR; j++) d[j*WW +: WW] = 8'(base + r * WPR + j);
            exp_wa.push_back(r);
            exp_wd.push_back(d);
            model[r] = d;
        end
        w = 0;
        loadWord = 8'(base);
        loadValid = 1;
        loadStart = 1;
        scanStart = with_scan;
        tick;
        loadStart = 0;
        scanStart = 0;
        n = 0;
        while (!loadDone && n < 200) begin
            bit acc;
            if (rowValid) rv_seen = 1;
            acc = loadReady && loadValid;
            tick;
            n++;
            if (acc) begin
                w++;
                loadWord = 8'(base + w);
            end
        end
        loadValid = 0;
        chk("load_done_seen", loadDone, 1);
    endtask

    task automatic do_scan(input int stall, input int hold, output int n);
        int held = 0;
        for (int r = 0; r < NC; r++) begin
            exp_ra.push_back(r);
            exp_rd.push_back(model[r]);
        end
        rowReady = 1;
        scanStart = 1;
        tick;
        scanStart = 0;
        n = 0;
        while (!scanDone && n < 100) begin
            if (rowValid && int'(rowIndex) == stall && held < hold) begin
                chk("stall_hold_data", rowOut, model[stall]);
                chk("stall_hold_index", rowIndex, stall);
                rowReady = 0;
                held++;
            end else rowReady = 1;
            tick;
            n++;
        end
        rowReady = 1;
        chk("scan_done_seen", scanDone, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;
        tick;
        // 1: full load of words 1..16
        do_load(1, 0, cyc);
        chk("load_cycles", cyc, 20);
        chk("row0_stored", mem[0], 32'h04030201);
        chk("row3_stored", mem[3], 32'h100F0E0D);
        // 2: back-to-back scan
        sd0 = scan_dones;
        do_scan(-1, 0, cyc);
        chk("scan_cycles", cyc, 8);
        repeat (3) tick;
        chk("scan_done_once", scan_dones - sd0, 1);
        // 3: consumer stalls on row 2
        do_scan(2, 5, cyc);
        chk("stall_scan_cycles", cyc, 13);
        // 4: simultaneous starts, load wins
        rv_seen = 0;
        do_load(17, 1, cyc);
        chk("dual_start_load_cycles", cyc, 20);
        repeat (3) begin
            tick;
            if (rowValid) rv_seen = 1;
        end
        chk("no_row_valid", rv_seen, 0);
        chk("idle_after_dual", busy, 0);
        chk("row1_dual_stored", mem[1], 32'h18171615);
        // 5: abort two words into row 1
        exp_wa.push_back(0);
        exp_wd.push_back(32'h67666564);
        ld0 = load_dones;
        k = 0;
        loadWord = 8'd100;
        loadValid = 1;
        loadStart = 1;
        tick;
        loadStart = 0;
        cyc = 0;
        while (k < 6 && cyc < 100) begin
            bit acc;
            acc = loadReady && loadValid;
            tick;
            cyc++;
            if (acc) begin
                k++;
                loadWord = 8'(100 + k);
            end
        end
        chk("abort_words_fed", k, 6);
        loadValid = 0;
        abort = 1;
        tick;
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_ctl", {loadReady, rowValid, storeWriteEnable}, 0);
        repeat (25) tick;
        chk("abort_no_load_done", load_dones - ld0, 0);
        chk("abort_row1_untouched", mem[1], 32'h18171615);
        do_load(33, 0, cyc);
        chk("reload_cycles", cyc, 20);
        // 6: reset while a row is presented
        rowReady = 0;
        scanStart = 1;
        tick;
        scanStart = 0;
        tick;
        chk("pre_reset_valid", rowValid, 1);
        chk("pre_reset_data", rowOut, 32'h24232221);
        rst_n = 0;
        #1;
        check_zero("midscan_reset");
        tick;
        rst_n = 1;
        tick;
        do_scan(-1, 0, cyc);
        chk("post_reset_scan_cycles", cyc, 8);
        repeat (2) tick;
        chk("write_queue_empty", exp_wa.size(), 0);
        chk("row_queue_empty", exp_ra.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
